// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory arbiter.
//   arb_state_e    - arbiter FSM state encoding
//   mem_cmd_t      - captured memory command (we, addr, wdata, bmask)
//   make_fetch_cmd - builds the read command issued on behalf of fetch
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int LS_BURST_MAX_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;

  // The command register is sized for the widest bus the arbiter supports;
  // narrower buses are zero-extended on capture and truncated on output.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [3:0]            bmask;
  } mem_cmd_t;

  // Fetch only ever reads whole words.
  function automatic mem_cmd_t make_fetch_cmd(input logic [CMD_ADDR_W-1:0] addr);
    mem_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.addr  = addr;
    cmd.wdata = '0;
    cmd.bmask = 4'hF;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts BUSY cycles without a memory ack and flags the
// cycle in which the transaction has to be aborted.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_clear      - restart the count (asserted on a grant)
//   i_active     - arbiter is waiting on memory
//   i_ack        - memory completion this cycle
//   o_expired    - this BUSY cycle is the last one before abort
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_q <= '0;
    end else if (i_active && !i_ack && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The count lags the BUSY cycle index by one, so TIMEOUT-1 marks the
  // TIMEOUT-th waiting cycle; the counter reaches TIMEOUT on that edge.
  assign o_expired = i_active && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch
// (read-only) and the load/store unit. Grants are combinational in IDLE,
// one transaction is outstanding at a time, and a watchdog aborts a
// transaction the memory never acknowledges.
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_if_* / o_if_*        - fetch request, grant, completion, data, error
//   i_ls_* / o_ls_*        - LSU request, grant, completion, data, error
//   o_mem_* / i_mem_*      - memory command and completion
//   o_busy                 - transaction in flight
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | no transaction; requests are granted combinationally
// ST_BUSY_IF | fetch read outstanding, waiting for ack or timeout
// ST_BUSY_LS | LSU load/store outstanding, waiting for ack or timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LS_BURST_MAX = LS_BURST_MAX_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_err,

  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [3:0]        i_ls_bmask,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_ls_err,

  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,

  output logic              o_busy
);

  localparam int STREAK_W = $clog2(LS_BURST_MAX + 1);

  arb_state_e          state_q;
  mem_cmd_t            cmd_q;
  logic [STREAK_W-1:0] streak_q;
  logic                mem_req_q;
  logic                if_rvalid_q, if_err_q;
  logic                ls_rvalid_q, ls_err_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

  logic idle;
  logic ls_win;
  logic if_gnt;
  logic ls_gnt;
  logic expired;

  assign idle = (state_q == ST_IDLE);

  // LSU normally wins; once it has taken LS_BURST_MAX grants in a row
  // while fetch was waiting, fetch gets the next slot.
  always_comb begin
    ls_win = i_ls_req && (!i_if_req || (streak_q != STREAK_W'(LS_BURST_MAX)));
    ls_gnt = !i_rst && idle && ls_win;
    if_gnt = !i_rst && idle && i_if_req && !ls_win;
  end

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (if_gnt || ls_gnt),
    .i_active  (!idle),
    .i_ack     (i_mem_ack),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      // Completion outputs are single-cycle; data is zero outside the pulse.
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;

      case (state_q)
        ST_IDLE: begin
          if (ls_gnt) begin
            cmd_q.we    <= i_ls_we;
            cmd_q.addr  <= CMD_ADDR_W'(i_ls_addr);
            cmd_q.wdata <= CMD_DATA_W'(i_ls_wdata);
            cmd_q.bmask <= i_ls_bmask;
            mem_req_q   <= 1'b1;
            state_q     <= ST_BUSY_LS;
            if (streak_q != STREAK_W'(LS_BURST_MAX)) begin
              streak_q <= streak_q + STREAK_W'(1);
            end
          end else if (if_gnt) begin
            cmd_q     <= make_fetch_cmd(CMD_ADDR_W'(i_if_addr));
            mem_req_q <= 1'b1;
            state_q   <= ST_BUSY_IF;
            streak_q  <= '0;
          end
        end

        ST_BUSY_IF: begin
          // Ack is tested first so it beats a coinciding expiry.
          if (i_mem_ack) begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= i_mem_rdata;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (expired) begin
            if_rvalid_q <= 1'b1;
            if_err_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        ST_BUSY_LS: begin
          if (i_mem_ack) begin
            ls_rvalid_q <= 1'b1;
            ls_rdata_q  <= cmd_q.we ? '0 : i_mem_rdata;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (expired) begin
            ls_rvalid_q <= 1'b1;
            ls_err_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_err    = if_err_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_ls_err    = ls_err_q;
  assign o_ls_rdata  = ls_rdata_q;

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = ADDR_W'(cmd_q.addr);
  assign o_mem_wdata = DATA_W'(cmd_q.wdata);
  assign o_mem_bmask = cmd_q.bmask;

  assign o_busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory responder checked every
// cycle against a transaction-level reference model. Each granted
// transaction is described by its grant cycle and chosen ack latency; the
// expected busy window, completion cycle, error and data follow from those.
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int LS_BURST_MAX = 4;
  localparam int TIMEOUT      = 16;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid, o_if_err;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_ls_req, i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic [3:0]        i_ls_bmask;
  logic              o_ls_gnt, o_ls_rvalid, o_ls_err;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .LS_BURST_MAX (LS_BURST_MAX),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .o_if_err    (o_if_err),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_bmask  (i_ls_bmask),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_ls_err    (o_ls_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: the one outstanding transaction.
  bit          has_txn = 1'b0;
  int          t_grant = 0;
  int          t_lat   = 0;
  int          t_done  = 0;
  bit          t_ls    = 1'b0;
  bit          t_we    = 1'b0;
  logic [31:0] t_addr  = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] t_rdata = '0;
  logic [3:0]  t_bm    = '0;
  int          streak  = 0;

  // Requesters: a request is held with its command until granted.
  bit          if_pend = 1'b0;
  logic [31:0] if_a    = '0;
  bit          ls_pend = 1'b0;
  bit          ls_w    = 1'b0;
  logic [31:0] ls_a    = '0;
  logic [31:0] ls_d    = '0;
  logic [3:0]  ls_m    = '0;

  // Stimulus knobs.
  int          p_if        = 0;
  int          p_ls        = 0;
  int          force_lat   = 0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd    = '0;
  bit          do_rst      = 1'b0;

  task automatic run_cycle();
    bit          busy_e, comp_e, err_e, ls_g, if_g;
    logic [31:0] rd_e;
    @(posedge clk);
    #1;
    cyc++;

    busy_e = has_txn && (cyc > t_grant) && (cyc <= t_done);
    comp_e = has_txn && (cyc == t_done + 1);
    err_e  = comp_e && (t_lat > TIMEOUT);
    rd_e   = (comp_e && !t_we && (t_lat <= TIMEOUT)) ? t_rdata : 32'h0;

    check_val("busy", o_busy, busy_e);
    check_val("mem_req", o_mem_req, busy_e);
    if (busy_e) begin
      check_val("mem_we", o_mem_we, t_we);
      check_val("mem_addr", o_mem_addr, t_addr);
      check_val("mem_wdata", o_mem_wdata, t_wdata);
      check_val("mem_bmask", o_mem_bmask, t_bm);
    end
    check_val("if_rvalid", o_if_rvalid, comp_e && !t_ls);
    check_val("if_err", o_if_err, err_e && !t_ls);
    check_val("if_rdata", o_if_rdata, t_ls ? 32'h0 : rd_e);
    check_val("ls_rvalid", o_ls_rvalid, comp_e && t_ls);
    check_val("ls_err", o_ls_err, err_e && t_ls);
    check_val("ls_rdata", o_ls_rdata, t_ls ? rd_e : 32'h0);

    if (!if_pend && ($urandom_range(99) < p_if)) begin
      if_pend = 1'b1;
      if_a    = $urandom;
    end
    if (!ls_pend && ($urandom_range(99) < p_ls)) begin
      ls_pend = 1'b1;
      ls_w    = $urandom_range(1);
      ls_a    = $urandom;
      ls_d    = $urandom;
      ls_m    = 4'($urandom_range(15));
    end

    i_rst      = do_rst;
    i_if_req   = if_pend;
    i_if_addr  = if_a;
    i_ls_req   = ls_pend;
    i_ls_we    = ls_w;
    i_ls_addr  = ls_a;
    i_ls_wdata = ls_d;
    i_ls_bmask = ls_m;
    if (busy_e && (cyc == t_grant + t_lat)) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = t_rdata;
    end else if (!busy_e && ((cyc == t_grant + t_lat) || ($urandom_range(3) == 0))) begin
      // ack while nothing is outstanding: late, stale or spurious
      i_mem_ack   = 1'b1;
      i_mem_rdata = $urandom;
    end else begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
    end
    #1;

    ls_g = !do_rst && !busy_e && ls_pend && (!if_pend || (streak != LS_BURST_MAX));
    if_g = !do_rst && !busy_e && if_pend && !ls_g;
    check_val("ls_gnt", o_ls_gnt, ls_g);
    check_val("if_gnt", o_if_gnt, if_g);

    if (do_rst) begin
      has_txn = 1'b0;
      streak  = 0;
    end else if (ls_g || if_g) begin
      has_txn = 1'b1;
      t_grant = cyc;
      if (force_lat > 0) t_lat = force_lat;
      else if ($urandom_range(7) == 0) t_lat = $urandom_range(TIMEOUT - 1, TIMEOUT + 3);
      else t_lat = $urandom_range(1, 5);
      t_done  = t_grant + ((t_lat < TIMEOUT) ? t_lat : TIMEOUT);
      t_rdata = force_rd_en ? force_rd : $urandom;
      t_ls    = ls_g;
      if (ls_g) begin
        t_we    = ls_w;
        t_addr  = ls_a;
        t_wdata = ls_d;
        t_bm    = ls_m;
        ls_pend = 1'b0;
        if (streak < LS_BURST_MAX) streak++;
      end else begin
        t_we    = 1'b0;
        t_addr  = if_a;
        t_wdata = 32'h0;
        t_bm    = 4'hF;
        if_pend = 1'b0;
        streak  = 0;
      end
    end
  endtask

  task automatic clear_knobs();
    p_if        = 0;
    p_ls        = 0;
    force_lat   = 0;
    force_rd_en = 1'b0;
    do_rst      = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_if_req    = 1'b0;
    i_if_addr   = '0;
    i_ls_req    = 1'b0;
    i_ls_we     = 1'b0;
    i_ls_addr   = '0;
    i_ls_wdata  = '0;
    i_ls_bmask  = '0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;

    // Reset with both requests pending: no grant while reset is high.
    clear_knobs();
    do_rst  = 1'b1;
    if_pend = 1'b1;
    if_a    = 32'h100;
    ls_pend = 1'b1;
    ls_w    = 1'b0;
    ls_a    = 32'h200;
    repeat (2) run_cycle();
    if_pend = 1'b0;
    ls_pend = 1'b0;
    do_rst  = 1'b0;
    repeat (2) run_cycle();

    // Fetch at 0x100, ack three cycles after the grant, data 0x13.
    if_pend     = 1'b1;
    if_a        = 32'h100;
    force_lat   = 3;
    force_rd_en = 1'b1;
    force_rd    = 32'h13;
    repeat (6) run_cycle();
    force_rd_en = 1'b0;

    // Simultaneous requests with streak 0: LSU first, fetch right after.
    ls_pend   = 1'b1;
    ls_w      = 1'b0;
    ls_a      = 32'h40;
    if_pend   = 1'b1;
    if_a      = 32'h104;
    force_lat = 2;
    repeat (10) run_cycle();

    // Store with bmask 0 and no ack: timeout, then a late ack.
    ls_pend   = 1'b1;
    ls_w      = 1'b1;
    ls_a      = 32'h80;
    ls_d      = 32'hDEAD_BEEF;
    ls_m      = 4'h0;
    force_lat = TIMEOUT + 2;
    repeat (24) run_cycle();

    // Ack in the final BUSY cycle: normal completion.
    ls_pend   = 1'b1;
    ls_w      = 1'b0;
    ls_a      = 32'hC0;
    force_lat = TIMEOUT;
    repeat (20) run_cycle();

    // Reset in the middle of a load: dropped without completion.
    ls_pend   = 1'b1;
    ls_w      = 1'b0;
    ls_a      = 32'hE0;
    force_lat = 10;
    repeat (3) run_cycle();
    do_rst = 1'b1;
    run_cycle();
    do_rst = 1'b0;
    repeat (14) run_cycle();

    // Continuous LSU traffic with fetch held: fetch gets every fifth slot,
    // and completions coincide with the next grant.
    p_if      = 100;
    p_ls      = 100;
    force_lat = 2;
    repeat (60) run_cycle();
    clear_knobs();
    repeat (8) run_cycle();

    // Random traffic with occasional resets.
    p_if = 35;
    p_ls = 55;
    for (int i = 0; i < 4000; i++) begin
      do_rst = ($urandom_range(499) == 0);
      run_cycle();
    end
    clear_knobs();
    repeat (TIMEOUT + 4) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; LS_BURST_MAX, 4, maximum consecutive LSU grants while fetch waits; TIMEOUT, 16, cycles to wait for memory ack before abort.
REQ-002 One clock; reset is synchronous and active-high; ports SHALL be (name, direction, width, meaning):
REQ-003 i_clk, in, 1, sole clock, rising edge.
REQ-004 i_rst, in, 1, synchronous active-high reset.
REQ-005 i_if_req, in, 1 / i_if_addr, in, ADDR_W: fetch read request and address.
REQ-006 o_if_gnt, out, 1 / o_if_rvalid, out, 1 / o_if_rdata, out, DATA_W / o_if_err, out, 1: fetch grant, completion pulse, read data, timeout flag.
REQ-007 i_ls_req, in, 1 / i_ls_we, in, 1 / i_ls_addr, in, ADDR_W / i_ls_wdata, in, DATA_W / i_ls_bmask, in, 4: LSU request, write enable, address, store data, byte mask.
REQ-008 o_ls_gnt, out, 1 / o_ls_rvalid, out, 1 / o_ls_rdata, out, DATA_W / o_ls_err, out, 1: LSU grant, completion pulse, load data, timeout flag.
REQ-009 o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, out: single-port memory command; i_mem_ack, in, 1 / i_mem_rdata, in, DATA_W: memory completion and read data.
REQ-010 o_busy, out, 1: high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, BUSY_IF, BUSY_LS.
REQ-012 In IDLE, grant SHALL be combinational: o_x_gnt high for exactly the cycle a request is accepted; the command is captured on that edge; next state BUSY_IF or BUSY_LS.
REQ-013 Requester SHALL hold req and command stable until gnt; no grant is issued in BUSY_*; a request arriving in BUSY_* waits.
REQ-014 Priority: LSU wins over fetch when both request, unless ls_streak == LS_BURST_MAX, in which case fetch wins.
REQ-015 ls_streak SHALL increment (saturating at LS_BURST_MAX) on each LSU grant and clear to 0 on each fetch grant; it holds when there is no grant.
REQ-016 In BUSY_*, o_mem_req SHALL be high with the captured command stable until i_mem_ack; fetch commands drive o_mem_we=0 and o_mem_bmask=4'hF.
REQ-017 On the i_mem_ack cycle, i_mem_rdata SHALL be registered; the next cycle the owner's rvalid pulses for 1 cycle with rdata valid and err=0; state returns to IDLE in that same cycle, so a new grant may coincide with rvalid.
REQ-018 A write SHALL also complete with o_ls_rvalid pulse; o_ls_rdata=0.
REQ-019 The wait counter SHALL clear at grant and increment each BUSY cycle without ack; on reaching TIMEOUT, abort: o_mem_req low next cycle, owner rvalid=1, err=1, rdata=0, state IDLE.
REQ-020 If ack and timeout expiry coincide, ack SHALL win (normal completion).
REQ-021 i_mem_ack in IDLE SHALL be ignored.
REQ-022 rvalid/err/rdata of the non-owner SHALL remain 0.
REQ-023 Bmask 0 writes SHALL be forwarded unchanged.

Reset
REQ-024 On i_rst high at a clock edge: state=IDLE, ls_streak=0, wait counter=0, all registered outputs 0; o_mem_req low the cycle after reset.
REQ-025 Reset mid-transaction SHALL drop it silently: no rvalid, no err; a late i_mem_ack is ignored.
REQ-026 While i_rst is high, o_if_gnt and o_ls_gnt SHALL be 0.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum, the command struct (we, addr, wdata, bmask) and default LS_BURST_MAX/TIMEOUT constants.
REQ-028 One sub-module mem_arb_watchdog (wait counter + timeout flag) SHALL be instantiated; priority logic stays in mem_arbiter.
REQ-029 Target 150-300 lines of RTL; no latches; single always_ff per register group.

Verification
REQ-030 Fetch only: if_req, addr 0x100, ack after 3 cycles, rdata 0x00000013 -> gnt in cycle 0, o_mem_req cycles 1-3, o_if_rvalid=1 with rdata 0x13 in cycle 4.
REQ-031 Simultaneous req: both requests high in IDLE, streak=0 -> o_ls_gnt, fetch waits; fetch is granted in the IDLE cycle after the LSU completes.
REQ-032 Starvation: LSU requests continuously, fetch held high -> 4 LSU grants, then a fetch grant, then streak resets and the LSU is granted.
REQ-033 Timeout: LSU store with no ack -> after 16 BUSY cycles, o_ls_rvalid=1, o_ls_err=1, rdata=0; a subsequent ack is ignored.
REQ-034 Ack on cycle 16 -> normal completion with err=0. A separate case asserts i_rst in BUSY_LS -> no rvalid, o_busy=0 next cycle.
REQ-035 Back-to-back: a fetch request pending at the LSU completion -> o_ls_rvalid and o_if_gnt are high in the same cycle.
